// File: rtl/crc_pkg.sv
// Shared CRC16 constants and frame-checker FSM state encoding.
package crc_pkg;

    localparam int                 CRC16_W        = 16;
    localparam logic [CRC16_W-1:0] CRC16_POLY_DEF = 16'h1021;
    localparam logic [CRC16_W-1:0] CRC16_INIT_DEF = 16'hFFFF;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

endpackage

// File: rtl/crc16_byte_step.sv
// Combinational one-byte CRC16 update, MSB first, no reflection.
module crc16_byte_step
    import crc_pkg::*;
#(
    parameter logic [CRC16_W-1:0] POLY = CRC16_POLY_DEF
) (
    input  logic [CRC16_W-1:0] i_crc,
    input  logic [7:0]         i_byte,
    output logic [CRC16_W-1:0] o_crc
);

    logic [CRC16_W-1:0] c;

    // NOTE: blocking assignments here are intentional; c is a combinational
    // temporary that ripples through the eight bit steps within one evaluation.
    always_comb begin
        c = i_crc;
        for (int b = 7; b >= 0; b--) begin
            if (c[CRC16_W-1] ^ i_byte[b]) c = (c << 1) ^ POLY;
            else                          c = c << 1;
        end
        o_crc = c;
    end

endmodule

// File: rtl/crc16_frame_checker.sv
// Receive-side CRC16 frame checker: framed words in, residue check and
// saturating good/bad frame counters out.
module crc16_frame_checker
    import crc_pkg::*;
#(
    parameter int                 DATA_W  = 32,
    parameter logic [CRC16_W-1:0] POLY    = CRC16_POLY_DEF,
    parameter logic [CRC16_W-1:0] INIT    = CRC16_INIT_DEF,
    parameter int                 CNT_W   = 16,
    parameter int                 BYTES_W = $clog2(DATA_W/8)+1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_din_valid,
    input  logic [DATA_W-1:0]  i_din,
    input  logic               i_sof,
    input  logic               i_eof,
    input  logic [BYTES_W-1:0] i_last_bytes,
    input  logic               i_clr_cnt,
    output logic               o_dout_valid,
    output logic               o_crc_ok,
    output logic [CRC16_W-1:0] o_dout,
    output logic               o_abort,
    output logic               o_orphan,
    output logic [CNT_W-1:0]   o_good_cnt,
    output logic [CNT_W-1:0]   o_bad_cnt
);

    localparam int NB = DATA_W / 8;

    state_t             state_q, state_d;
    logic [CRC16_W-1:0] crc_q, crc_d, word_crc;
    logic [CRC16_W-1:0] tap [0:NB];
    logic               res_valid, res_ok, res_abort, res_orphan;
    logic [1:0]         good_inc, bad_inc;
    logic [CNT_W:0]     good_sum, bad_sum;

    // A sof word always restarts from INIT, whatever the current state.
    assign tap[0] = i_sof ? INIT : crc_q;

    for (genvar k = 0; k < NB; k++) begin : g_step
        crc16_byte_step #(.POLY(POLY)) u_step (
            .i_crc  (tap[k]),
            .i_byte (i_din[DATA_W-1-8*k -: 8]),
            .o_crc  (tap[k+1])
        );
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        word_crc = tap[NB];
        if (i_eof) begin
            for (int k = 1; k < NB; k++) begin
                if (i_last_bytes == BYTES_W'(k)) word_crc = tap[k];
            end
        end
        res_ok = (word_crc == '0);

        state_d    = state_q;
        crc_d      = crc_q;
        res_valid  = 1'b0;
        res_abort  = 1'b0;
        res_orphan = 1'b0;
        if (i_din_valid) begin
            if (i_sof) begin
                res_abort = (state_q == ACTIVE);
                if (i_eof) begin
                    res_valid = 1'b1;
                    state_d   = IDLE;
                    crc_d     = INIT;
                end else begin
                    state_d = ACTIVE;
                    crc_d   = word_crc;
                end
            end else if (state_q == IDLE) begin
                res_orphan = 1'b1;
            end else if (i_eof) begin
                res_valid = 1'b1;
                state_d   = IDLE;
                crc_d     = INIT;
            end else begin
                crc_d = word_crc;
            end
        end

        // An abort and a bad single-word frame can land in the same cycle.
        good_inc = {1'b0, res_valid & res_ok};
        bad_inc  = {1'b0, res_valid & ~res_ok} + {1'b0, res_abort};
        good_sum = {1'b0, o_good_cnt} + (CNT_W+1)'(good_inc);
        bad_sum  = {1'b0, o_bad_cnt}  + (CNT_W+1)'(bad_inc);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            crc_q        <= INIT;
            o_dout_valid <= 1'b0;
            o_crc_ok     <= 1'b0;
            o_dout       <= '0;
            o_abort      <= 1'b0;
            o_orphan     <= 1'b0;
            o_good_cnt   <= '0;
            o_bad_cnt    <= '0;
        end else begin
            state_q      <= state_d;
            crc_q        <= crc_d;
            o_dout_valid <= res_valid;
            o_abort      <= res_abort;
            o_orphan     <= res_orphan;
            if (res_valid) begin
                o_dout   <= word_crc;
                o_crc_ok <= res_ok;
            end
            if (i_clr_cnt) begin
                o_good_cnt <= '0;
                o_bad_cnt  <= '0;
            end else begin
                o_good_cnt <= good_sum[CNT_W] ? '1 : good_sum[CNT_W-1:0];
                o_bad_cnt  <= bad_sum[CNT_W]  ? '1 : bad_sum[CNT_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_crc16_frame_checker.sv
// Directed bench: 8-bit and 32-bit checkers plus a 2-bit-counter instance
// sharing the 32-bit stimulus.
module tb_crc16_frame_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    int          tests_run = 0;
    int          tests_failed = 0;

    always #5 clk = ~clk;

    // 8-bit instance
    logic        a_valid = 1'b0, a_sof = 1'b0, a_eof = 1'b0;
    logic [7:0]  a_din = '0;
    logic [0:0]  a_lb = '0;
    logic        a_dv, a_ok, a_abort, a_orphan;
    logic [15:0] a_dout, a_good, a_bad;

    // 32-bit instances
    logic        b_valid = 1'b0, b_sof = 1'b0, b_eof = 1'b0;
    logic [31:0] b_din = '0;
    logic [2:0]  b_lb = '0;
    logic        b_dv, b_ok, b_abort, b_orphan;
    logic [15:0] b_dout, b_good, b_bad;
    logic        c_dv, c_ok, c_abort, c_orphan;
    logic [15:0] c_dout;
    logic [1:0]  c_good, c_bad;

    crc16_frame_checker #(.DATA_W(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_din_valid(a_valid), .i_din(a_din),
        .i_sof(a_sof), .i_eof(a_eof), .i_last_bytes(a_lb), .i_clr_cnt(clr),
        .o_dout_valid(a_dv), .o_crc_ok(a_ok), .o_dout(a_dout), .o_abort(a_abort),
        .o_orphan(a_orphan), .o_good_cnt(a_good), .o_bad_cnt(a_bad)
    );

    crc16_frame_checker #(.DATA_W(32)) dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_din_valid(b_valid), .i_din(b_din),
        .i_sof(b_sof), .i_eof(b_eof), .i_last_bytes(b_lb), .i_clr_cnt(clr),
        .o_dout_valid(b_dv), .o_crc_ok(b_ok), .o_dout(b_dout), .o_abort(b_abort),
        .o_orphan(b_orphan), .o_good_cnt(b_good), .o_bad_cnt(b_bad)
    );

    crc16_frame_checker #(.DATA_W(32), .CNT_W(2)) dut_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_din_valid(b_valid), .i_din(b_din),
        .i_sof(b_sof), .i_eof(b_eof), .i_last_bytes(b_lb), .i_clr_cnt(clr),
        .o_dout_valid(c_dv), .o_crc_ok(c_ok), .o_dout(c_dout), .o_abort(c_abort),
        .o_orphan(c_orphan), .o_good_cnt(c_good), .o_bad_cnt(c_bad)
    );

    // Reference bitwise CRC16 (MSB first, no reflection, no final XOR).
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) r = (r[15] ^ d[i]) ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic a_byte(input logic [7:0] d, input logic s, input logic e);
        a_din = d; a_sof = s; a_eof = e; a_valid = 1'b1;
        tick();
        a_valid = 1'b0; a_sof = 1'b0; a_eof = 1'b0; a_din = '0;
    endtask

    task automatic b_word(input logic [31:0] d, input logic s, input logic e, input logic [2:0] lb);
        b_din = d; b_sof = s; b_eof = e; b_lb = lb; b_valid = 1'b1;
        tick();
        b_valid = 1'b0; b_sof = 1'b0; b_eof = 1'b0; b_lb = '0; b_din = '0;
    endtask

    task automatic b_good_frame();
        b_word(32'h31323334, 1'b1, 1'b0, 3'd0);
        b_word(32'h35363738, 1'b0, 1'b0, 3'd0);
        b_word(32'h3929B1AA, 1'b0, 1'b1, 3'd3);
    endtask

    task automatic test_reset();
        #12;
        tests_run++; if ({a_dv, a_ok, a_abort, a_orphan, a_dout, a_good, a_bad} !== '0) begin
            tests_failed++; $display("FAIL reset_a: outputs %h want 0", {a_dv, a_ok, a_abort, a_orphan, a_dout, a_good, a_bad}); end
        tests_run++; if ({b_dv, b_ok, b_abort, b_orphan, b_dout, b_good, b_bad} !== '0) begin
            tests_failed++; $display("FAIL reset_b: outputs %h want 0", {b_dv, b_ok, b_abort, b_orphan, b_dout, b_good, b_bad}); end
        #10 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_byte_frame();
        logic [7:0] msg [11] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};
        for (int i = 0; i < 11; i++) a_byte(msg[i], i == 0, i == 10);
        tests_run++; if (a_dv !== 1'b1) begin tests_failed++; $display("FAIL b8_valid: got %b want 1", a_dv); end
        tests_run++; if (a_dout !== 16'h0000) begin tests_failed++; $display("FAIL b8_dout: got %h want 0000", a_dout); end
        tests_run++; if (a_ok !== 1'b1) begin tests_failed++; $display("FAIL b8_ok: got %b want 1", a_ok); end
        tests_run++; if (a_good !== 16'd1) begin tests_failed++; $display("FAIL b8_good: got %0d want 1", a_good); end
        tick();
        tests_run++; if (a_dv !== 1'b0) begin tests_failed++; $display("FAIL b8_pulse: got %b want 0", a_dv); end
    endtask

    task automatic test_partial_word();
        b_word(32'h31323334, 1'b1, 1'b0, 3'd0);
        tests_run++; if (b_dv !== 1'b0) begin tests_failed++; $display("FAIL pw_early: got %b want 0", b_dv); end
        tick(); tick();
        b_word(32'h35363738, 1'b0, 1'b0, 3'd0);
        tick();
        b_word(32'h3929B1AA, 1'b0, 1'b1, 3'd3);
        tests_run++; if (b_dv !== 1'b1) begin tests_failed++; $display("FAIL pw_valid: got %b want 1", b_dv); end
        tests_run++; if (b_dout !== 16'h0000) begin tests_failed++; $display("FAIL pw_dout: got %h want 0000", b_dout); end
        tests_run++; if (b_ok !== 1'b1) begin tests_failed++; $display("FAIL pw_ok: got %b want 1", b_ok); end
        tests_run++; if (b_good !== 16'd1 || b_bad !== 16'd0) begin
            tests_failed++; $display("FAIL pw_cnt: got %0d/%0d want 1/0", b_good, b_bad); end
    endtask

    task automatic test_bad_crc();
        logic [7:0] msg [11] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h39, 8'h39, 8'h29, 8'hB1};
        logic [15:0] exp = 16'hFFFF;
        for (int i = 0; i < 11; i++) exp = crc_step(exp, msg[i]);
        b_word(32'h31323334, 1'b1, 1'b0, 3'd0);
        b_word(32'h35363739, 1'b0, 1'b0, 3'd0);
        b_word(32'h3929B1AA, 1'b0, 1'b1, 3'd3);
        tests_run++; if (b_ok !== 1'b0) begin tests_failed++; $display("FAIL bad_ok: got %b want 0", b_ok); end
        tests_run++; if (b_dout !== exp) begin tests_failed++; $display("FAIL bad_dout: got %h want %h", b_dout, exp); end
        tests_run++; if (b_good !== 16'd1 || b_bad !== 16'd1) begin
            tests_failed++; $display("FAIL bad_cnt: got %0d/%0d want 1/1", b_good, b_bad); end
    endtask

    task automatic test_abort();
        logic [15:0] exp = 16'hFFFF;
        exp = crc_step(exp, 8'h31); exp = crc_step(exp, 8'h32);
        exp = crc_step(exp, 8'h33); exp = crc_step(exp, 8'h34);
        b_word(32'hDEADBEEF, 1'b1, 1'b0, 3'd0);
        b_word(32'h31323334, 1'b1, 1'b1, 3'd0);
        tests_run++; if (b_abort !== 1'b1 || b_dv !== 1'b1) begin
            tests_failed++; $display("FAIL abort_pulse: abort %b valid %b want 1 1", b_abort, b_dv); end
        tests_run++; if (b_dout !== exp || b_ok !== (exp == 16'h0)) begin
            tests_failed++; $display("FAIL abort_dout: got %h/%b want %h/%b", b_dout, b_ok, exp, exp == 16'h0); end
        tests_run++; if (b_bad !== 16'd3 || b_good !== 16'd1) begin
            tests_failed++; $display("FAIL abort_cnt: got %0d/%0d want 1/3", b_good, b_bad); end
        tick();
        tests_run++; if (b_abort !== 1'b0 || b_dv !== 1'b0) begin
            tests_failed++; $display("FAIL abort_clear: abort %b valid %b want 0 0", b_abort, b_dv); end
    endtask

    task automatic test_orphan();
        b_word(32'h12345678, 1'b0, 1'b0, 3'd0);
        tests_run++; if (b_orphan !== 1'b1 || b_dv !== 1'b0) begin
            tests_failed++; $display("FAIL orphan_pulse: orphan %b valid %b want 1 0", b_orphan, b_dv); end
        tests_run++; if (b_good !== 16'd1 || b_bad !== 16'd3) begin
            tests_failed++; $display("FAIL orphan_cnt: got %0d/%0d want 1/3", b_good, b_bad); end
        tick();
        tests_run++; if (b_orphan !== 1'b0) begin tests_failed++; $display("FAIL orphan_clear: got %b want 0", b_orphan); end
    endtask

    task automatic test_reset_mid_frame();
        b_word(32'h31323334, 1'b1, 1'b0, 3'd0);
        #3 rst_n = 1'b0;
        #1;
        tests_run++; if ({b_dv, b_ok, b_abort, b_orphan, b_dout, b_good, b_bad} !== '0) begin
            tests_failed++; $display("FAIL rst_async: outputs %h want 0", {b_dv, b_ok, b_abort, b_orphan, b_dout, b_good, b_bad}); end
        #3 rst_n = 1'b1;
        tick();
        b_word(32'h35363738, 1'b0, 1'b0, 3'd0);
        b_word(32'h3929B1AA, 1'b0, 1'b1, 3'd3);
        tests_run++; if (b_dv !== 1'b0 || b_orphan !== 1'b1) begin
            tests_failed++; $display("FAIL rst_lost: valid %b orphan %b want 0 1", b_dv, b_orphan); end
        tests_run++; if (b_good !== 16'd0 || b_bad !== 16'd0) begin
            tests_failed++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", b_good, b_bad); end
    endtask

    task automatic test_saturation();
        for (int i = 1; i <= 5; i++) begin
            b_good_frame();
            tests_run++; if (c_good !== 2'((i > 3) ? 3 : i)) begin
                tests_failed++; $display("FAIL sat_cnt%0d: got %0d want %0d", i, c_good, (i > 3) ? 3 : i); end
        end
        tests_run++; if (b_good !== 16'd5) begin tests_failed++; $display("FAIL sat_wide: got %0d want 5", b_good); end
        b_word(32'h31323334, 1'b1, 1'b0, 3'd0);
        b_word(32'h35363738, 1'b0, 1'b0, 3'd0);
        clr = 1'b1;
        b_word(32'h3929B1AA, 1'b0, 1'b1, 3'd3);
        clr = 1'b0;
        tests_run++; if (c_dv !== 1'b1 || c_ok !== 1'b1) begin
            tests_failed++; $display("FAIL clr_frame: valid %b ok %b want 1 1", c_dv, c_ok); end
        tests_run++; if (c_good !== 2'd0 || b_good !== 16'd0) begin
            tests_failed++; $display("FAIL clr_wins: got %0d/%0d want 0/0", c_good, b_good); end
    endtask

    initial begin
        test_reset();
        test_byte_frame();
        test_partial_word();
        test_bad_crc();
        test_abort();
        test_orphan();
        test_reset_mid_frame();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
